// File: rtl/cache_rd_sched.sv
// Read scheduler: four ID queues drained round-robin, one outstanding cache read at a time.
// Optional WAIT watchdog enabled by defining SCHED_TIMEOUT_EN.
module cache_rd_sched #(
  parameter string PLATFORM = "xilinx",
  parameter int    QDEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_sched_ID_wr,
  input  logic [7:0] in_sched_ID,
  input  logic [1:0] in_sched_qid,
  input  logic [3:0] in_sched_pause,
  input  logic       in_sched_valid_wr,
  output logic       out_sched_ID_wr,
  output logic [7:0] out_sched_ID,
  output logic [3:0] out_sched_qfull,
  output logic       out_sched_drop,
  output logic       out_sched_timeout
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t               state_q, state_d;
  logic [1:0]           win_q, win_d;
  logic [1:0]           last_q, last_d;
  logic [3:0][CW-1:0]   cnt_q, cnt_d;
  logic [3:0][AW-1:0]   wptr_q, wptr_d;
  logic [3:0][AW-1:0]   rptr_q, rptr_d;
  logic [3:0]           qfull_q, qfull_d;
  logic                 drop_q, drop_d;
  logic                 valid_q, valid_d;

  logic [3:0] full, nonempty, eligible, push, pop;
  logic       issue, found;
  logic [1:0] idx;
  logic [7:0] head;
  logic [AW+1:0] wr_addr, rd_addr;

  always_comb begin
    full     = '0;
    nonempty = '0;
    for (int q = 0; q < 4; q++) begin
      full[q]     = (cnt_q[q] == CW'(QDEPTH));
      nonempty[q] = (cnt_q[q] != '0);
    end
  end

  assign eligible = nonempty & ~in_sched_pause;

  // Queue bookkeeping; a pop frees the slot the same cycle, so a full queue accepts a push then
  always_comb begin
    push    = '0;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    qfull_d = '0;
    for (int q = 0; q < 4; q++) begin
      push[q]    = in_sched_ID_wr && (in_sched_qid == 2'(q)) && (!full[q] || pop[q]);
      cnt_d[q]   = cnt_q[q] + CW'(push[q]) - CW'(pop[q]);
      wptr_d[q]  = wptr_q[q] + AW'(push[q]);
      rptr_d[q]  = rptr_q[q] + AW'(pop[q]);
      qfull_d[q] = (cnt_d[q] == CW'(QDEPTH));
    end
    drop_d = in_sched_ID_wr && full[in_sched_qid] && !pop[in_sched_qid];
  end

  assign wr_addr = {in_sched_qid, wptr_q[in_sched_qid]};
  assign rd_addr = {win_q, rptr_q[win_q]};

  generate
    if (PLATFORM == "xilinx") begin : g_store
      (* ram_style = "distributed" *) logic [7:0] mem [4*QDEPTH];
      always_ff @(posedge clk) if (|push) mem[wr_addr] <= in_sched_ID;
      assign head = mem[rd_addr];
    end else begin : g_store
      logic [7:0] mem [4*QDEPTH];
      always_ff @(posedge clk) if (|push) mem[wr_addr] <= in_sched_ID;
      assign head = mem[rd_addr];
    end
  endgenerate

`ifdef SCHED_TIMEOUT_EN
  logic [11:0] tmr_q, tmr_d;
  logic        tmr_hit;
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    pop     = '0;
    issue   = 1'b0;
    found   = 1'b0;
    idx     = '0;
`ifdef SCHED_TIMEOUT_EN
    tmr_d   = tmr_q;
    tmr_hit = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        for (int i = 1; i <= 4; i++) begin
          idx = last_q + 2'(i);
          if (!found && eligible[idx]) begin
            found = 1'b1;
            win_d = idx;
          end
        end
        if (found) begin
          state_d = ISSUE;
          last_d  = win_d;
        end
      end
      ISSUE: begin
        issue       = 1'b1;
        pop[win_q]  = 1'b1;
        state_d     = WAIT;
`ifdef SCHED_TIMEOUT_EN
        tmr_d       = '0;
`endif
      end
      WAIT: begin
        // completion is registered first, which spaces reads at least three cycles apart
        if (valid_q) state_d = IDLE;
`ifdef SCHED_TIMEOUT_EN
        else if (tmr_q == 12'hFFF) begin
          if (!in_sched_valid_wr) begin
            tmr_hit = 1'b1;
            state_d = IDLE;
          end
        end else tmr_d = tmr_q + 12'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
    valid_d = in_sched_valid_wr && (state_q == WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      qfull_q <= '0;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      qfull_q <= qfull_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end
  assign out_sched_timeout = tmr_hit;
`else
  assign out_sched_timeout = 1'b0;
`endif

  assign out_sched_ID_wr = issue;
  assign out_sched_ID    = issue ? head : 8'h00;
  assign out_sched_qfull = qfull_q;
  assign out_sched_drop  = drop_q;

endmodule

// File: tb/tb_cache_rd_sched.sv
// Directed bench for cache_rd_sched: latency, round-robin order, full/drop, push+pop on full, reset, watchdog.
module tb_cache_rd_sched;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_sched_ID_wr;
  logic [7:0] in_sched_ID;
  logic [1:0] in_sched_qid;
  logic [3:0] in_sched_pause;
  logic       in_sched_valid_wr;
  logic       out_sched_ID_wr;
  logic [7:0] out_sched_ID;
  logic [3:0] out_sched_qfull;
  logic       out_sched_drop;
  logic       out_sched_timeout;

  int n_cmp = 0;
  int n_err = 0;
  int drop_cnt = 0;
  logic [7:0] issue_log[$];

  cache_rd_sched #(.PLATFORM("xilinx"), .QDEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_sched_ID_wr(in_sched_ID_wr), .in_sched_ID(in_sched_ID), .in_sched_qid(in_sched_qid),
    .in_sched_pause(in_sched_pause), .in_sched_valid_wr(in_sched_valid_wr),
    .out_sched_ID_wr(out_sched_ID_wr), .out_sched_ID(out_sched_ID),
    .out_sched_qfull(out_sched_qfull), .out_sched_drop(out_sched_drop),
    .out_sched_timeout(out_sched_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_sched_ID_wr) issue_log.push_back(out_sched_ID);
    if (out_sched_drop) drop_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_id(input logic [7:0] id, input logic [1:0] qid);
    in_sched_ID_wr = 1'b1;
    in_sched_ID    = id;
    in_sched_qid   = qid;
    step();
    in_sched_ID_wr = 1'b0;
  endtask

  task automatic complete();
    in_sched_valid_wr = 1'b1;
    step();
    in_sched_valid_wr = 1'b0;
  endtask

  task automatic wait_log(input int n, input string tag);
    int k = 0;
    while (issue_log.size() < n && k < 100) begin
      step();
      k++;
    end
    chk(tag, issue_log.size() >= n, 1);
  endtask

  initial begin
    rst = 1'b1;
    in_sched_ID_wr = 0; in_sched_ID = 0; in_sched_qid = 0;
    in_sched_pause = 0; in_sched_valid_wr = 0;
    step(); step();
    chk("rst id_wr", out_sched_ID_wr, 0);
    chk("rst id", out_sched_ID, 0);
    chk("rst qfull", out_sched_qfull, 0);
    chk("rst drop", out_sched_drop, 0);
    chk("rst timeout", out_sched_timeout, 0);
    rst = 1'b0;
    step();

    // latency t+2, single outstanding, back-to-back spacing
    write_id(8'h21, 2'd2);
    chk("lat t+1 quiet", out_sched_ID_wr, 0);
    step();
    chk("lat t+2 strobe", out_sched_ID_wr, 1);
    chk("lat t+2 id", out_sched_ID, 8'h21);
    write_id(8'h22, 2'd1);
    for (int i = 0; i < 5; i++) begin
      chk("one outstanding", out_sched_ID_wr, 0);
      step();
    end
    complete();
    chk("b2b c+1 quiet", out_sched_ID_wr, 0);
    step();
    chk("b2b c+2 quiet", out_sched_ID_wr, 0);
    step();
    chk("b2b c+3 strobe", out_sched_ID_wr, 1);
    chk("b2b c+3 id", out_sched_ID, 8'h22);
    step();
    complete();
    step(); step();
    issue_log.delete();

    // round-robin order
    write_id(8'h10, 2'd0);
    write_id(8'h20, 2'd1);
    write_id(8'h30, 2'd2);
    write_id(8'h40, 2'd3);
    write_id(8'h11, 2'd0);
    for (int n = 1; n <= 5; n++) begin
      wait_log(n, "rr wait");
      complete();
    end
    step(); step(); step(); step();
    chk("rr count", issue_log.size(), 5);
    if (issue_log.size() == 5) begin
      chk("rr 0", issue_log[0], 8'h10);
      chk("rr 1", issue_log[1], 8'h20);
      chk("rr 2", issue_log[2], 8'h30);
      chk("rr 3", issue_log[3], 8'h40);
      chk("rr 4", issue_log[4], 8'h11);
    end

    // fill queue 1 while paused, one overflow
    issue_log.delete();
    drop_cnt = 0;
    in_sched_pause = 4'b0010;
    for (int i = 0; i < 17; i++) write_id(8'h50 + 8'(i), 2'd1);
    chk("full drop pulse", out_sched_drop, 1);
    chk("full qfull", out_sched_qfull, 4'b0010);
    step();
    chk("full drop one cycle", out_sched_drop, 0);
    chk("full drop count", drop_cnt, 1);
    chk("paused no issue", issue_log.size(), 0);
    in_sched_pause = 4'b0000;
    for (int n = 1; n <= 16; n++) begin
      wait_log(n, "drain wait");
      complete();
    end
    for (int i = 0; i < 10; i++) step();
    chk("drain count", issue_log.size(), 16);
    if (issue_log.size() == 16)
      for (int i = 0; i < 16; i++) chk("drain order", issue_log[i], 8'h50 + 8'(i));
    chk("drain qfull", out_sched_qfull, 0);

    // push and pop on a full queue in the same cycle
    issue_log.delete();
    drop_cnt = 0;
    in_sched_pause = 4'b1000;
    for (int i = 0; i < 16; i++) write_id(8'h80 + 8'(i), 2'd3);
    write_id(8'hA0, 2'd0);
    wait_log(1, "pp first");
    in_sched_pause = 4'b0000;
    chk("pp first id", issue_log[0], 8'hA0);
    chk("pp qfull before", out_sched_qfull, 4'b1000);
    complete();
    step();
    step();
    chk("pp pop strobe", out_sched_ID_wr, 1);
    chk("pp pop id", out_sched_ID, 8'h80);
    write_id(8'h77, 2'd3);
    chk("pp no drop", out_sched_drop, 0);
    chk("pp qfull kept", out_sched_qfull, 4'b1000);
    complete();
    for (int n = 3; n <= 18; n++) begin
      wait_log(n, "pp drain");
      complete();
    end
    step(); step(); step(); step();
    chk("pp count", issue_log.size(), 18);
    if (issue_log.size() == 18) begin
      chk("pp 1", issue_log[1], 8'h80);
      chk("pp 16", issue_log[16], 8'h8F);
      chk("pp last", issue_log[17], 8'h77);
    end
    chk("pp drops", drop_cnt, 0);

    // reset in WAIT with five entries still queued
    issue_log.delete();
    for (int i = 0; i < 6; i++) write_id(8'hB0 + 8'(i), 2'd0);
    wait_log(1, "rst setup");
    step();
    #2 rst = 1'b1;
    #1;
    chk("mid rst id_wr", out_sched_ID_wr, 0);
    chk("mid rst id", out_sched_ID, 0);
    chk("mid rst qfull", out_sched_qfull, 0);
    chk("mid rst drop", out_sched_drop, 0);
    chk("mid rst timeout", out_sched_timeout, 0);
    step(); step();
    rst = 1'b0;
    issue_log.delete();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) complete();
      else step();
    end
    chk("post rst no issue", issue_log.size(), 0);
    in_sched_pause = 4'b1111;
    write_id(8'hD3, 2'd3);
    write_id(8'hD0, 2'd0);
    step();
    chk("post rst paused", issue_log.size(), 0);
    in_sched_pause = 4'b0000;
    wait_log(1, "ptr wait0");
    complete();
    wait_log(2, "ptr wait1");
    complete();
    step(); step();
    if (issue_log.size() == 2) begin
      chk("ptr first q0", issue_log[0], 8'hD0);
      chk("ptr then q3", issue_log[1], 8'hD3);
    end else chk("ptr count", issue_log.size(), 2);

    // watchdog
    issue_log.delete();
`ifdef SCHED_TIMEOUT_EN
    write_id(8'hE0, 2'd0);
    write_id(8'hE1, 2'd0);
    chk("to issue", out_sched_ID_wr, 1);
    chk("to issue id", out_sched_ID, 8'hE0);
    for (int i = 0; i < 4095; i++) step();
    chk("to early quiet", out_sched_timeout, 0);
    step();
    chk("to pulse", out_sched_timeout, 1);
    step();
    chk("to pulse one cycle", out_sched_timeout, 0);
    chk("to idle quiet", out_sched_ID_wr, 0);
    step();
    chk("to next strobe", out_sched_ID_wr, 1);
    chk("to next id", out_sched_ID, 8'hE1);
    step();
    complete();
`else
    write_id(8'hE0, 2'd0);
    write_id(8'hE1, 2'd0);
    for (int i = 0; i < 300; i++) begin
      step();
      if (out_sched_timeout !== 1'b0) chk("no timeout", out_sched_timeout, 0);
    end
    chk("wait holds", issue_log.size(), 1);
    complete();
    wait_log(2, "wait release");
    complete();
    if (issue_log.size() == 2) chk("release id", issue_log[1], 8'hE1);
`endif
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cache_rd_sched.md
CACHE_RD_SCHED -- requirements
Module: cache_rd_sched

Interface
REQ-001 Parameter PLATFORM, default "xilinx": target vendor, passed through to the FIFO storage.
REQ-002 Parameter QDEPTH, default 16: entries per queue, power of two, range 4..64.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_sched_ID_wr  input  1  one-cycle strobe: descriptor valid.
REQ-006 in_sched_ID  input  8  packet ID returned by the data cache on write.
REQ-007 in_sched_qid  input  2  destination queue of the descriptor, 0..3.
REQ-008 in_sched_pause  input  4  per-queue pause; bit q set excludes queue q from selection.
REQ-009 in_sched_valid_wr  input  1  end-of-packet strobe from the data cache output side.
REQ-010 out_sched_ID_wr  output  1  one-cycle read-request strobe to the data cache.
REQ-011 out_sched_ID  output  8  ID to read; meaningful only while out_sched_ID_wr=1.
REQ-012 out_sched_qfull  output  4  bit q = queue q holds QDEPTH entries.
REQ-013 out_sched_drop  output  1  one-cycle pulse: descriptor discarded because its queue was full.
REQ-014 out_sched_timeout  output  1  one-cycle pulse: read abandoned by watchdog (REQ-031).

Function
REQ-015 The block SHALL hold four FIFO queues of 8-bit IDs, each QDEPTH deep, with a per-queue count of width log2(QDEPTH)+1.
REQ-016 A descriptor write SHALL push in_sched_ID into queue in_sched_qid in the same cycle when that queue is not full.
REQ-017 A write to a full queue SHALL be discarded, with out_sched_drop=1 in the following cycle and queue contents unchanged.
REQ-018 A push and a pop on the same queue in the same cycle SHALL both take effect, leaving the count unchanged; this also holds when the queue is full.
REQ-019 FSM states SHALL be IDLE, ISSUE and WAIT.
REQ-020 IDLE: when any queue q is non-empty and in_sched_pause[q]=0, the FSM SHALL latch the winner and go to ISSUE; otherwise it stays in IDLE.
REQ-021 Arbitration SHALL be round-robin, searching from (last served queue + 1) mod 4 upward with wrap-around; the last served pointer resets to 3, so queue 0 wins first.
REQ-022 ISSUE: for exactly one cycle, out_sched_ID_wr=1 and out_sched_ID=head of the winner; the head SHALL be popped and the FSM SHALL go to WAIT.
REQ-023 WAIT: in_sched_valid_wr=1 SHALL return the FSM to IDLE in the next cycle; at most one read request is outstanding at any time.
REQ-024 in_sched_valid_wr asserted in IDLE or ISSUE SHALL be ignored.
REQ-025 Pause asserted after a queue has won SHALL NOT abort its ISSUE.
REQ-026 Latency: a descriptor written in cycle t to an empty queue with the FSM in IDLE SHALL produce out_sched_ID_wr in cycle t+2.
REQ-027 Back-to-back: after in_sched_valid_wr in cycle t, the next out_sched_ID_wr SHALL be no earlier than t+3.
REQ-028 out_sched_qfull SHALL be registered and reflect counts after the previous cycle's push and pop.

Reset
REQ-029 While rst=1: all queues empty, FSM=IDLE, last served pointer=3, out_sched_ID_wr=0, out_sched_ID=0, out_sched_qfull=0, out_sched_drop=0, out_sched_timeout=0.
REQ-030 Reset asserted mid-operation SHALL discard all queued and outstanding IDs, with no completion expected afterwards.

Configuration
REQ-031 Macro SCHED_TIMEOUT_EN defined: a 12-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle; at value 4095 without in_sched_valid_wr, the FSM SHALL go to IDLE and pulse out_sched_timeout for one cycle.
REQ-032 SCHED_TIMEOUT_EN undefined: no counter is built, out_sched_timeout is tied to 0, and WAIT is left only via in_sched_valid_wr.

Verification
REQ-033 Reset, then ID 0x21 to queue 2 at cycle t -> out_sched_ID_wr=1 with ID 0x21 at t+2; no second strobe before in_sched_valid_wr.
REQ-034 IDs 0x10, 0x20, 0x30, 0x40 to queues 0-3, and 0x11 to queue 0; completion pulsed 2 cycles after each issue -> issue order 0x10, 0x20, 0x30, 0x40, 0x11.
REQ-035 QDEPTH+1 writes to queue 1 with pause[1]=1 -> qfull[1]=1 and one drop pulse; release pause -> exactly 16 IDs issued in FIFO order.
REQ-036 Queue 3 full and in WAIT; completion plus a simultaneous write of 0x77 to queue 3 in the cycle of its pop -> no drop, count stays 16, 0x77 issued last.
REQ-037 rst pulsed in WAIT with 5 entries queued -> all outputs 0, queues empty, no issue until a new write arrives.
REQ-038 With SCHED_TIMEOUT_EN: issue with no completion -> out_sched_timeout pulse 4095 cycles after WAIT entry, and the next queued ID is issued 2 cycles later.
